// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO read-side UART drain.
// State encoding and 8N1 framing constants.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } state_e;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT = 1'b1;
    localparam int UART_FRAME_BITS = 10;
    localparam int DATA_W = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Held at zero while clear is high so each state starts a fresh period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bit_tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops bytes from a registered-read FIFO and sends them as 8N1 UART.
// All outputs come straight from flops.
import fifo_uart_pkg::*;

module fifo_uart_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W = fifo_uart_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("fifo_uart_drain: CLKS_PER_BIT must be 2..65535");
    end
    if (DATA_W != 8) begin : g_bad_dw
        $error("fifo_uart_drain: DATA_W must be 8");
    end

    localparam int IW = $clog2(DATA_W);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    state_e            state_q;
    logic              tx_q;
    logic              rd_en_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] shreg_q;
    logic [IW-1:0]     bit_idx_q;
    logic              tick;
    logic              tmr_clear;

    // Counter only runs in the timed states; it re-zeroes on every entry.
    assign tmr_clear = !(state_q == START || state_q == DATA ||
                         state_q == STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .bit_tick(tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_q      <= UART_STOP_BIT;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ena && !fifo_empty) begin
                        state_q <= POP;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                POP: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    shreg_q <= fifo_rd_data;
                    tx_q    <= UART_START_BIT;
                    state_q <= START;
                end
                START: begin
                    if (tick) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shreg_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg_q <= shreg_q >> 1;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                            tx_q    <= UART_STOP_BIT;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= shreg_q[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        done_q <= 1'b1;
                        if (ena && !fifo_empty) begin
                            state_q <= POP;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign byte_done  = done_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Scoreboard bench: FIFO model feeds the drain, monitor decodes UART.
// Extra instances at CLKS_PER_BIT=2 and 16 measure bit widths.
module tb_fifo_uart_drain;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       byte_done;

    logic [1:0] ena_s = 2'b11;
    logic [1:0] emp_s = 2'b11;
    logic [1:0] rd_s;
    logic [1:0] tx_s;
    logic [1:0] busy_s;
    logic [1:0] done_s;
    logic [7:0] d81 = 8'h81;

    int n_pass = 0;
    int n_total = 0;
    int n_push = 0;
    int n_pop = 0;
    logic [7:0] mem [256];
    logic [7:0] exp_q [$];

    int mon_k = -1;
    int cyc = 0;
    int done_cyc = 0;
    int last_gap = -1;
    int done_cnt = 0;
    int busy_falls = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (n_push == n_pop);

    fifo_uart_drain #(.CLKS_PER_BIT(N)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .tx(tx), .busy(busy), .byte_done(byte_done)
    );

    fifo_uart_drain #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena_s[0]), .fifo_empty(emp_s[0]),
        .fifo_rd_en(rd_s[0]), .fifo_rd_data(d81),
        .tx(tx_s[0]), .busy(busy_s[0]), .byte_done(done_s[0])
    );

    fifo_uart_drain #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena_s[1]), .fifo_empty(emp_s[1]),
        .fifo_rd_en(rd_s[1]), .fifo_rd_data(d81),
        .tx(tx_s[1]), .busy(busy_s[1]), .byte_done(done_s[1])
    );

    task automatic check(input bit ok, input string nm,
                         input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                      nm, act, act, req, req);
    endtask

    // Ideal 8N1 frame: bit 0 start, 1..8 payload LSB first, 9 stop.
    function automatic logic fbit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic push(input logic [7:0] b);
        mem[n_push % 256] = b;
        n_push = n_push + 1;
        exp_q.push_back(b);
    endtask

    // Registered-read FIFO model.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            check(n_push != n_pop, "no_underflow", n_push - n_pop, 1);
            if (n_push != n_pop) begin
                fifo_rd_data <= mem[n_pop % 256];
                n_pop <= n_pop + 1;
            end
        end
    end

    // Monitor: decode every frame on tx and score it.
    initial begin : monitor
        logic       samp [40];
        logic       prev_rd;
        logic       prev_busy;
        logic       chk_low;
        int         ferr;
        int         mism;
        logic [7:0] dec;
        logic [7:0] e;
        prev_rd = 1'b0;
        prev_busy = 1'b0;
        chk_low = 1'b0;
        ferr = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                mon_k = -1;
                prev_rd = 1'b0;
                prev_busy = 1'b0;
                chk_low = 1'b0;
            end else begin
                if (prev_rd) check(!fifo_rd_en, "rd_en_width", fifo_rd_en, 0);
                prev_rd = fifo_rd_en;
                if (chk_low) check(!byte_done, "done_single", byte_done, 0);
                chk_low = 1'b0;
                if (prev_busy && !busy) busy_falls++;
                prev_busy = busy;
                if (byte_done) done_cnt++;
                if (mon_k < 0 && !tx) begin
                    mon_k = 0;
                    ferr = 0;
                    last_gap = cyc - done_cyc;
                end
                if (mon_k >= 0 && mon_k < 40) begin
                    samp[mon_k] = tx;
                    if (!busy || byte_done) ferr++;
                    mon_k++;
                end else if (mon_k == 40) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        mism = 0;
                        for (int j = 0; j < 40; j++)
                            if (samp[j] !== fbit(e, j / N)) mism++;
                        for (int i = 0; i < 8; i++)
                            dec[i] = samp[N + N * i + N / 2];
                        check(dec == e, "frame_data", dec, e);
                        check(mism == 0, "frame_timing", mism, 0);
                        check(byte_done, "byte_done_pulse", byte_done, 1);
                        check(ferr == 0, "busy_in_frame", ferr, 0);
                        chk_low = 1'b1;
                    end
                    mon_k = -1;
                end
                if (byte_done) done_cyc = cyc;
            end
        end
    end

    task automatic wait_drain(input int budget, input string nm);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && !busy && mon_k < 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(k < budget, nm, k, budget);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pos(input int pos, input string nm);
        int k;
        k = 0;
        while (mon_k != pos && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(k < 200, nm, k, 200);
    endtask

    task automatic run_len(input int k, input logic v, input int cap,
                           output int len);
        len = 0;
        while (tx_s[k] == v && len < cap) begin
            len++;
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int p0;
        int d0;
        int b0;
        int bad_rd;
        int bad_tx;
        int bad_busy;
        int bad_done;
        int w;
        int len;
        int n;
        rst_n = 1'b0;
        ena = 1'b0;
        repeat (3) @(negedge clk);
        check(tx == 1'b1, "reset_tx", tx, 1);
        check(fifo_rd_en == 1'b0, "reset_rd_en", fifo_rd_en, 0);
        check(busy == 1'b0, "reset_busy", busy, 0);
        check(byte_done == 1'b0, "reset_done", byte_done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0xA5.
        ena = 1'b1;
        p0 = n_pop;
        d0 = done_cnt;
        push(8'hA5);
        wait_drain(200, "drain_a5");
        check(n_pop - p0 == 1, "a5_pops", n_pop - p0, 1);
        check(done_cnt - d0 == 1, "a5_done_cnt", done_cnt - d0, 1);

        // Back-to-back 0x00, 0xFF.
        p0 = n_pop;
        b0 = busy_falls;
        push(8'h00);
        push(8'hFF);
        wait_drain(300, "drain_b2b");
        check(n_pop - p0 == 2, "b2b_pops", n_pop - p0, 2);
        check(busy_falls - b0 == 1, "b2b_busy_falls", busy_falls - b0, 1);
        check(last_gap == 2, "b2b_gap", last_gap, 2);

        // Empty FIFO with ena high.
        bad_rd = 0; bad_tx = 0; bad_busy = 0; bad_done = 0;
        repeat (200) begin
            @(negedge clk);
            if (fifo_rd_en) bad_rd++;
            if (!tx) bad_tx++;
            if (busy) bad_busy++;
            if (byte_done) bad_done++;
        end
        check(bad_rd == 0, "empty_rd_en", bad_rd, 0);
        check(bad_tx == 0, "empty_tx", bad_tx, 0);
        check(bad_busy == 0, "empty_busy", bad_busy, 0);
        check(bad_done == 0, "empty_done", bad_done, 0);

        // ena dropped during data bit 3.
        d0 = done_cnt;
        push(8'h5A);
        push(8'hC3);
        wait_pos(N * 4 + 1, "reach_bit3");
        ena = 1'b0;
        w = 0;
        while (!(exp_q.size() == 1 && mon_k < 0 && !busy) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check(w < 200, "ena_low_finish", w, 200);
        check(done_cnt - d0 == 1, "ena_low_done", done_cnt - d0, 1);
        p0 = n_pop;
        bad_rd = 0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_rd_en) bad_rd++;
        end
        check(bad_rd == 0 && n_pop == p0, "ena_low_no_pop", bad_rd, 0);
        ena = 1'b1;
        @(negedge clk);
        check(fifo_rd_en == 1'b1, "ena_rise_latency", fifo_rd_en, 1);
        wait_drain(200, "drain_ena");

        // Reset during data bit 5.
        push(8'h77);
        wait_pos(N * 6 + 1, "reach_bit5");
        #1 rst_n = 1'b0;
        #1;
        check(tx == 1'b1, "rst_async_tx", tx, 1);
        check(busy == 1'b0, "rst_async_busy", busy, 0);
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        p0 = n_pop;
        push(8'h3C);
        wait_drain(200, "drain_3c");
        check(n_pop - p0 == 1, "post_rst_pops", n_pop - p0, 1);

        // Bit widths at CLKS_PER_BIT = 2 and 16 with byte 0x81.
        for (int k = 0; k < 2; k++) begin
            n = (k == 0) ? 2 : 16;
            emp_s[k] = 1'b0;
            w = 0;
            while (!rd_s[k] && w < 20) begin
                @(negedge clk);
                w++;
            end
            emp_s[k] = 1'b1;
            check(w < 20, "cpb_pop", w, 20);
            w = 0;
            while (tx_s[k] && w < 20) begin
                @(negedge clk);
                w++;
            end
            check(w < 20, "cpb_start_seen", w, 20);
            run_len(k, 1'b0, 12 * n, len);
            check(len == n, "cpb_start_width", len, n);
            run_len(k, 1'b1, 12 * n, len);
            check(len == n, "cpb_bit0_width", len, n);
            run_len(k, 1'b0, 12 * n, len);
            check(len == 6 * n, "cpb_bits1to6_width", len, 6 * n);
            run_len(k, 1'b1, 2 * n, len);
            check(len == 2 * n, "cpb_bit7_stop_width", len, 2 * n);
            check(done_s[k] == 1'b1, "cpb_done", done_s[k], 1);
            repeat (4) @(negedge clk);
        end

        // Random bytes with random ena gaps.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) push(8'($urandom));
            repeat ($urandom_range(0, 60)) begin
                @(negedge clk);
                ena = ($urandom_range(0, 3) != 0);
            end
        end
        ena = 1'b1;
        wait_drain(2000, "drain_random");
        check(n_push == n_pop, "random_all_popped", n_pop, n_push);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
